decoder_scan_sequencer: RTL and testbench

- Registered 3-bit select sequencer that sits directly upstream of the 3-to-8 active-low decoder and drives its A, B, C inputs.
- Steps through the eight select codes at a programmable dwell rate, or one code per STEP pulse, in either direction.
- Supports synchronous load of an arbitrary code.
- Flags wrap-around for the display/scan logic that consumes the decoder outputs.

---
 rtl/scan_pkg.sv | 13 +
 rtl/scan_next_code.sv | 48 ++++
 rtl/decoder_scan_sequencer.sv | 116 +++++++++++
 tb/tb_decoder_scan_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared constants and types for the decoder scan sequencer.
// Latency: n/a (package). Backpressure: n/a.
package scan_pkg;

    localparam int CODE_W    = 3;
    localparam int NUM_CODES = 8;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/scan_next_code.sv
// Next-code generator: one step in direction DIR, or nearest enabled code when SCAN_MASK_EN is defined.
// Latency: combinational. Backpressure: none.
// found_o low means no other code is enabled and the caller must hold.
module scan_next_code
    import scan_pkg::*;
(
    input  code_t                code_i,
    input  logic                 dir_i,
`ifdef SCAN_MASK_EN
    input  logic [NUM_CODES-1:0] mask_i,
`endif
    output code_t                nxt_code_o,
    output logic                 wrap_o,
    output logic                 found_o
);

`ifdef SCAN_MASK_EN
    code_t cand;

    // Scan farthest-first so the nearest enabled candidate is the last writer.
    always_comb begin
        nxt_code_o = code_i;
        wrap_o     = 1'b0;
        found_o    = 1'b0;
        cand       = code_i;
        for (int k = NUM_CODES - 1; k >= 1; k--) begin
            cand = (dir_i == DIR_DOWN) ? code_i - code_t'(k) : code_i + code_t'(k);
            if (mask_i[cand]) begin
                nxt_code_o = cand;
                wrap_o     = (dir_i == DIR_DOWN) ? (cand > code_i) : (cand < code_i);
                found_o    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        found_o = 1'b1;
        if (dir_i == DIR_DOWN) begin
            nxt_code_o = code_i - code_t'(1);
            wrap_o     = (code_i == '0);
        end else begin
            nxt_code_o = code_i + code_t'(1);
            wrap_o     = (code_i == '1);
        end
    end
`endif

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Registered 3-bit select sequencer for a 3-to-8 decoder: free-run dwell, single-step, load, wrap flag.
// Latency: one cycle from sampled control to CODE/WRAP/ADV. Backpressure: none, always accepts.
// Optional SCAN_MASK_EN adds MASK/VALID and skips disabled codes.
module decoder_scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL   = 4,
    parameter int DWELL_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_L,
    input  logic              EN,
    input  logic              STEP,
    input  logic              DIR,
    input  logic              LOAD,
    input  logic [CODE_W-1:0] LOAD_VAL,
`ifdef SCAN_MASK_EN
    input  logic [NUM_CODES-1:0] MASK,
    output logic              VALID,
`endif
    output logic [CODE_W-1:0] CODE,
    output logic              A,
    output logic              C,
    output logic              B,
    output logic              WRAP,
    output logic              ADV
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    code_t              code_q, code_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               wrap_q, wrap_d;
    logic               adv_q, adv_d;
    logic               do_adv;

    code_t              nxt_code;
    logic               nxt_wrap;
    logic               nxt_found;

    scan_next_code u_next (
        .code_i     (code_q),
        .dir_i      (DIR),
`ifdef SCAN_MASK_EN
        .mask_i     (MASK),
`endif
        .nxt_code_o (nxt_code),
        .wrap_o     (nxt_wrap),
        .found_o    (nxt_found)
    );

    always_comb begin
        code_d  = code_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        adv_d   = 1'b0;
        do_adv  = 1'b0;
        if (LOAD) begin
            code_d  = LOAD_VAL;
            dwell_d = '0;
            adv_d   = (LOAD_VAL != code_q);
        end else if (EN) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                do_adv  = 1'b1;
            end else begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end else if (STEP) begin
            do_adv = 1'b1;
        end
        if (do_adv && nxt_found) begin
            code_d = nxt_code;
            wrap_d = nxt_wrap;
            adv_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            code_q  <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
            adv_q   <= 1'b0;
        end else begin
            code_q  <= code_d;
            dwell_q <= dwell_d;
            wrap_q  <= wrap_d;
            adv_q   <= adv_d;
        end
    end

`ifdef SCAN_MASK_EN
    logic valid_q, valid_d;

    assign valid_d = MASK[code_d];

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign VALID = valid_q;
`endif

    assign CODE = code_q;
    assign A    = code_q[2];
    assign C    = code_q[1];
    assign B    = code_q[0];
    assign WRAP = wrap_q;
    assign ADV  = adv_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: two instances (DWELL=4 and DWELL=2) share stimulus;
// a behavioural model pushes expected state per cycle, popped and compared after each edge.
module tb_decoder_scan_sequencer;

    typedef struct packed {
        logic [2:0] code;
        logic [7:0] dwell;
        logic       wrap;
        logic       adv;
        logic       valid;
    } ms_t;

    logic       clk = 1'b0;
    logic       rst_n, en, step, dir, load;
    logic [2:0] load_val;
    logic [7:0] mskv;

    logic [2:0] code4, code2;
    logic       a4, b4, c4, w4, v4_adv;
    logic       a2, b2, c2, w2, v2_adv;
    logic       val4, val2;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    ms_t m4, m2;
    ms_t q4[$];
    ms_t q2[$];

    always #5 clk = ~clk;

    decoder_scan_sequencer #(.DWELL(4), .DWELL_W(8)) u4 (
        .CLK(clk), .RESET_L(rst_n), .EN(en), .STEP(step), .DIR(dir),
        .LOAD(load), .LOAD_VAL(load_val),
`ifdef SCAN_MASK_EN
        .MASK(mskv), .VALID(val4),
`endif
        .CODE(code4), .A(a4), .C(c4), .B(b4), .WRAP(w4), .ADV(v4_adv)
    );

    decoder_scan_sequencer #(.DWELL(2), .DWELL_W(8)) u2 (
        .CLK(clk), .RESET_L(rst_n), .EN(en), .STEP(step), .DIR(dir),
        .LOAD(load), .LOAD_VAL(load_val),
`ifdef SCAN_MASK_EN
        .MASK(mskv), .VALID(val2),
`endif
        .CODE(code2), .A(a2), .C(c2), .B(b2), .WRAP(w2), .ADV(v2_adv)
    );

`ifndef SCAN_MASK_EN
    assign val4 = 1'b0;
    assign val2 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s (cycle %0d): observed %0h, expected %0h", tag, cyc, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Behavioural model: walk code by code so wrap is detected by crossing 7<->0.
    function automatic ms_t mstep(ms_t s, int dw);
        ms_t        n;
        bit         go;
        bit         crossed;
        logic [2:0] cur;
        n       = s;
        n.wrap  = 1'b0;
        n.adv   = 1'b0;
        go      = 1'b0;
        if (load) begin
            n.code  = load_val;
            n.dwell = 8'd0;
            n.adv   = (load_val != s.code);
        end else if (en) begin
            if (s.dwell == 8'(dw - 1)) begin
                n.dwell = 8'd0;
                go      = 1'b1;
            end else begin
                n.dwell = s.dwell + 8'd1;
            end
        end else if (step) begin
            go = 1'b1;
        end
        if (go) begin
            cur     = s.code;
            crossed = 1'b0;
            for (int k = 1; k < 8; k++) begin
                if (!dir) begin
                    if (cur == 3'd7) crossed = 1'b1;
                    cur = cur + 3'd1;
                end else begin
                    if (cur == 3'd0) crossed = 1'b1;
                    cur = cur - 3'd1;
                end
                if (mskv[cur]) begin
                    n.code = cur;
                    n.wrap = crossed;
                    n.adv  = 1'b1;
                    break;
                end
            end
        end
        n.valid = mskv[n.code];
        return n;
    endfunction

    task automatic tick();
        ms_t e;
        q4.push_back(mstep(m4, 4));
        q2.push_back(mstep(m2, 2));
        m4 = q4[$];
        m2 = q2[$];
        @(posedge clk);
        #1;
        cyc++;
        e = q4.pop_front();
        chk("u4.code", 8'(code4), 8'(e.code));
        chk("u4.wrap", 8'(w4), 8'(e.wrap));
        chk("u4.adv",  8'(v4_adv), 8'(e.adv));
        chk("u4.acb",  8'({a4, c4, b4}), 8'(e.code));
`ifdef SCAN_MASK_EN
        chk("u4.valid", 8'(val4), 8'(e.valid));
`endif
        e = q2.pop_front();
        chk("u2.code", 8'(code2), 8'(e.code));
        chk("u2.wrap", 8'(w2), 8'(e.wrap));
        chk("u2.adv",  8'(v2_adv), 8'(e.adv));
        chk("u2.acb",  8'({a2, c2, b2}), 8'(e.code));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] y;
        rst_n = 1'b0; en = 1'b0; step = 1'b0; dir = 1'b0; load = 1'b0;
        load_val = 3'd0; mskv = 8'hFF;
        m4 = '0; m2 = '0;
        #12;
        chk("rst.code4", 8'(code4), 8'd0);
        chk("rst.wrap4", 8'(w4), 8'd0);
        chk("rst.adv4",  8'(v4_adv), 8'd0);
        chk("rst.code2", 8'(code2), 8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Free-run up from reset; DWELL=2 instance wraps on the 16th edge.
        en = 1'b1; dir = 1'b0;
        ticks(16);
        chk("fr.u2.code", 8'(code2), 8'd0);
        chk("fr.u2.wrap", 8'(w2), 8'd1);
        chk("fr.u4.code", 8'(code4), 8'd4);

        // Async reset between edges at CODE=5.
        ticks(4);
        chk("mid.u4.code", 8'(code4), 8'd5);
        #3 rst_n = 1'b0;
        #1;
        chk("arst.code4", 8'(code4), 8'd0);
        chk("arst.code2", 8'(code2), 8'd0);
        m4 = '0; m2 = '0;
        #1 rst_n = 1'b1;
        ticks(3);
        chk("arst.hold3", 8'(code4), 8'd0);
        tick();
        chk("arst.first", 8'(code4), 8'd1);
        chk("arst.adv",   8'(v4_adv), 8'd1);

        // Single-step down from 1.
        en = 1'b0; dir = 1'b1; step = 1'b1;
        tick();
        chk("st.to0",    8'(code4), 8'd0);
        chk("st.to0.w",  8'(w4), 8'd0);
        step = 1'b0;
        tick();
        chk("st.hold",   8'(code4), 8'd0);
        chk("st.hold.a", 8'(v4_adv), 8'd0);
        step = 1'b1;
        tick();
        chk("st.to7",    8'(code4), 8'd7);
        chk("st.to7.w",  8'(w4), 8'd1);
        tick();
        chk("st.to6",    8'(code4), 8'd6);
        step = 1'b0;

        // Load at dwell count DWELL-1 wins over the pending advance.
        en = 1'b1; dir = 1'b0;
        ticks(3);
        load = 1'b1; load_val = 3'd6;
        tick();
        load = 1'b0;
        chk("ld.code", 8'(code4), 8'd6);
        chk("ld.adv",  8'(v4_adv), 8'd0);
        chk("ld.acb",  8'({a4, c4, b4}), 8'b110);
        y = ~(8'd1 << {a4, c4, b4});
        chk("ld.dec_y", y, 8'b1011_1111);
        ticks(3);
        chk("ld.dw3", 8'(code4), 8'd6);
        tick();
        chk("ld.dw4", 8'(code4), 8'd7);

        // Freeze: 2 dwell cycles, 10 idle, advance 2 cycles after EN returns.
        ticks(2);
        en = 1'b0;
        ticks(10);
        chk("fz.hold", 8'(code4), 8'd7);
        en = 1'b1;
        tick();
        chk("fz.c1",   8'(code4), 8'd7);
        tick();
        chk("fz.c2",   8'(code4), 8'd0);
        chk("fz.wrap", 8'(w4), 8'd1);

        // Load of a differing value pulses ADV.
        load = 1'b1; load_val = 3'd3;
        tick();
        load = 1'b0;
        chk("ld3.code", 8'(code4), 8'd3);
        chk("ld3.adv",  8'(v4_adv), 8'd1);

        // Free-run down, model-checked.
        dir = 1'b1;
        ticks(12);
        en = 1'b0;

`ifdef SCAN_MASK_EN
        load = 1'b1; load_val = 3'd0;
        tick();
        load = 1'b0;
        mskv = 8'h81; dir = 1'b0; step = 1'b1;
        tick();
        chk("mk.to7",   8'(code4), 8'd7);
        chk("mk.wrap0", 8'(w4), 8'd0);
        tick();
        chk("mk.to0",   8'(code4), 8'd0);
        chk("mk.wrap1", 8'(w4), 8'd1);
        mskv = 8'h00;
        tick();
        chk("mk.hold",  8'(code4), 8'd0);
        chk("mk.noadv", 8'(v4_adv), 8'd0);
        chk("mk.valid", 8'(val4), 8'd0);
        step = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
